// File: rtl/shift_iter_if.sv
// Bundles the start/busy/done request and result signals between the stall logic and the shifter.
// Handshake: start is sampled only while busy is low; busy stays high for the whole operation, and done pulses for one cycle when Out is final.
interface shift_iter_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
);
    logic             start;
    logic [WIDTH-1:0] In;
    logic [1:0]       Op;
    logic [CNT_W-1:0] Cnt;
    logic [WIDTH-1:0] Out;
    logic             busy;
    logic             done;

    modport master (
        output start, In, Op, Cnt,
        input  Out, busy, done
    );

    modport slave (
        input  start, In, Op, Cnt,
        output Out, busy, done
    );
endinterface

// File: rtl/shift_iter.sv
// Iterative shifter/rotator: moves the operand one bit per clock for Cnt clocks.
// The IDLE, SHIFT and DONE states are visible on o_dbg_state.
module shift_iter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    shift_iter_if.slave bus,
    output logic [1:0]  o_dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_data;
    logic [1:0]       r_op;
    logic [CNT_W-1:0] r_rem;
    logic [WIDTH-1:0] w_step;
    logic             w_accept;

    assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && bus.start;

    // Single-bit transform of the working word, selected by the latched opcode.
    always_comb begin
        w_step = r_data;
        case (r_op)
            2'b00: w_step = {r_data[WIDTH-2:0], 1'b0};
            2'b01: w_step = {r_data[0], r_data[WIDTH-1:1]};
            2'b10: w_step = {1'b0, r_data[WIDTH-1:1]};
            2'b11: w_step = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
            default: w_step = r_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_op    <= '0;
            r_rem   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_data <= bus.In;
                r_op   <= bus.Op;
                r_rem  <= bus.Cnt;
            end else if (r_state == S_SHIFT) begin
                r_data <= w_step;
                r_rem  <= r_rem - CNT_W'(1);
            end
        end
    end

    // DONE behaves like IDLE for acceptance, so back-to-back requests need no bubble.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_next_state = (bus.Cnt != '0) ? S_SHIFT : S_DONE;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_SHIFT: begin
                w_next_state = (r_rem == CNT_W'(1)) ? S_DONE : S_SHIFT;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy    = (r_state == S_SHIFT);
        bus.done    = (r_state == S_DONE);
        o_dbg_state = r_state;
    end

    assign bus.Out = r_data;
endmodule

// File: tb/tb_shift_iter.sv
// Randomized bench for shift_iter: results and latencies come from an arithmetic model
// of shift/rotate-by-N and are compared through one checking task.
module tb_shift_iter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];
    int          lat_q[$];
    logic [15:0] last_out;

    shift_iter_if #(.WIDTH(16), .CNT_W(4)) bus ();

    shift_iter #(.WIDTH(16), .CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Shift/rotate by n positions in one step, using plain 32-bit arithmetic.
    function automatic logic [15:0] ref_shift(input logic [1:0] op, input logic [15:0] din,
                                              input int n);
        logic [31:0] x;
        logic [31:0] r;
        x = {16'h0000, din};
        case (op)
            2'b00:   r = x << n;
            2'b01:   r = (x >> n) | (x << (16 - n));
            2'b10:   r = x >> n;
            default: r = (x << n) | (x >> (16 - n));
        endcase
        return r[15:0];
    endfunction

    task automatic scramble_inputs();
        bus.In  = 16'($urandom);
        bus.Op  = 2'($urandom_range(0, 3));
        bus.Cnt = 4'($urandom_range(0, 15));
    endtask

    // Called just after a falling edge; the request is accepted at the next rising edge.
    task automatic launch(input logic [1:0] op, input logic [15:0] din, input logic [3:0] cnt);
        bus.start = 1'b1;
        bus.In    = din;
        bus.Op    = op;
        bus.Cnt   = cnt;
        exp_q.push_back(ref_shift(op, din, int'(cnt)));
        lat_q.push_back(int'(cnt) + 1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        scramble_inputs();
    endtask

    // Returns just after the falling edge on which done is seen.
    task automatic wait_done(input string tag, input bit interfere);
        int          c = 0;
        int          busy_n = 0;
        bit          seen = 1'b0;
        logic [15:0] exp_out;
        int          exp_lat;
        exp_out = exp_q.pop_front();
        exp_lat = lat_q.pop_front();
        while (!seen && c < 40) begin
            @(negedge clk);
            c++;
            if (bus.done) seen = 1'b1;
            else if (bus.busy) busy_n++;
            if (!seen && bus.busy && interfere) begin
                bus.start = ($urandom_range(0, 2) == 0);
                scramble_inputs();
            end else begin
                bus.start = 1'b0;
            end
        end
        check({tag, "_seen_done"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, "_latency"}, 32'(c), 32'(exp_lat));
            check({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_lat - 1));
            check({tag, "_busy_in_done"}, 32'(bus.busy), 32'd0);
            check({tag, "_out"}, 32'(bus.Out), 32'(exp_out));
        end
        last_out = exp_out;
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        check({tag, "_idle_done"}, 32'(bus.done), 32'd0);
        check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_idle_hold"}, 32'(bus.Out), 32'(last_out));
    endtask

    initial begin
        bus.start = 1'b0;
        bus.In    = '0;
        bus.Op    = '0;
        bus.Cnt   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out", 32'(bus.Out), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        rst = 1'b0;

        launch(2'b00, 16'h0001, 4'd4);
        wait_done("sll4", 1'b0);
        check("sll4_const", 32'(bus.Out), 32'h0010);
        check_idle("sll4");

        launch(2'b01, 16'h0001, 4'd1);
        wait_done("ror1", 1'b0);
        check("ror1_const", 32'(bus.Out), 32'h8000);
        launch(2'b11, 16'hF00F, 4'd4);
        wait_done("rol4", 1'b0);
        check("rol4_const", 32'(bus.Out), 32'h00FF);

        launch(2'b10, 16'h8000, 4'd15);
        wait_done("srl15", 1'b0);
        check("srl15_const", 32'(bus.Out), 32'h0001);
        launch(2'b10, 16'hA5A5, 4'd0);
        wait_done("cnt0", 1'b0);
        check("cnt0_const", 32'(bus.Out), 32'hA5A5);
        check_idle("cnt0");

        launch(2'b00, 16'h0003, 4'd8);
        wait_done("ignore_start", 1'b1);
        check("ignore_start_const", 32'(bus.Out), 32'h0300);

        launch(2'b00, 16'h1234, 4'd2);
        wait_done("b2b_first", 1'b0);
        launch(2'b01, 16'h0002, 4'd1);
        wait_done("b2b_second", 1'b0);
        check("b2b_const", 32'(bus.Out), 32'h0001);
        check_idle("b2b");

        launch(2'b00, 16'h00FF, 4'd8);
        void'(exp_q.pop_back());
        void'(lat_q.pop_back());
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_out", 32'(bus.Out), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_state", 32'(dbg_state), 32'd0);
        launch(2'b11, 16'h8001, 4'd3);
        wait_done("after_abort", 1'b0);
        check_idle("after_abort");

        for (int i = 0; i < 60; i++) begin
            launch(2'($urandom_range(0, 3)), 16'($urandom), 4'($urandom_range(0, 15)));
            wait_done("rand", 1'b1);
            if ($urandom_range(0, 9) < 7) check_idle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
